// File: rtl/free_list_pkg.sv
// Shared rename-stage types: physical tag and the packets exchanged between
// the ROB, the ID/dispatch stage and the free list.
package free_list_pkg;

  localparam int PHYS_REGS = 64;
  localparam int ARCH_REGS = 32;
  localparam int FL_SZ     = PHYS_REGS - ARCH_REGS;

  localparam int TAG_W     = $clog2(PHYS_REGS);
  localparam int FL_IDX_W  = $clog2(FL_SZ);
  localparam int FL_CNT_W  = FL_IDX_W + 1;

  typedef struct packed {
    logic [TAG_W-1:0] phys_reg;
    logic             valid;
  } TAG;

  typedef struct packed {
    logic retire_en;
    TAG   retire_t;
    TAG   retire_t_old;
  } ROB_MT_PACKET;

  typedef struct packed {
    logic alloc_en;
  } ID_FL_PACKET;

  typedef struct packed {
    TAG                  free_t;
    logic [FL_CNT_W-1:0] free_cnt;
  } FL_ID_PACKET;

endpackage

// File: rtl/free_list_if.sv
// Bundle of the retire (ROB->MT), allocate (ID->FL) and offer (FL->ID) packets.
interface free_list_if;
  import free_list_pkg::*;

  ROB_MT_PACKET rob_mt_packet;
  ID_FL_PACKET  id_fl_packet;
  FL_ID_PACKET  fl_id_packet;

  modport master (
    output rob_mt_packet,
    output id_fl_packet,
    input  fl_id_packet
  );

  modport slave (
    input  rob_mt_packet,
    input  id_fl_packet,
    output fl_id_packet
  );
endinterface

// File: rtl/free_list.sv
// Circular FIFO of free physical tags: dispatch pops the head tag, retirement
// pushes back the superseded T_old. Reset preloads tags ARCH_REGS..PHYS_REGS-1.
module free_list
  import free_list_pkg::*;
#(
  parameter int PHYS_REGS = free_list_pkg::PHYS_REGS,
  parameter int ARCH_REGS = free_list_pkg::ARCH_REGS,
  parameter int FL_SZ     = PHYS_REGS - ARCH_REGS
) (
  input  logic        clock,
  input  logic        reset,
  free_list_if.slave  fl_bus,
  output logic        fl_error
);

  localparam int IDX_W = $clog2(FL_SZ);
  localparam int CNT_W = IDX_W + 1;

  logic [TAG_W-1:0] entries [FL_SZ];
  logic [IDX_W-1:0] head_idx;
  logic [IDX_W-1:0] tail_idx;
  logic [CNT_W-1:0] count;

  logic empty;
  logic full;
  logic pop;
  logic push_req;
  logic push;
  logic overflow;

  // retire_t is carried on the shared retire packet but has no role here
  logic unused_retire_t;
  assign unused_retire_t = ^fl_bus.rob_mt_packet.retire_t;

  always_comb begin
    empty    = (count == '0);
    full     = (count == CNT_W'(FL_SZ));
    pop      = fl_bus.id_fl_packet.alloc_en && !empty;
    push_req = fl_bus.rob_mt_packet.retire_en && fl_bus.rob_mt_packet.retire_t_old.valid;
    // a push into a full list is only legal when a pop frees the head slot this cycle
    push     = push_req && (!full || pop);
    overflow = push_req && full && !pop;
  end

  always_comb begin
    fl_bus.fl_id_packet                 = '0;
    fl_bus.fl_id_packet.free_t.phys_reg = entries[head_idx];
    fl_bus.fl_id_packet.free_t.valid    = !empty;
    fl_bus.fl_id_packet.free_cnt        = FL_CNT_W'(count);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < FL_SZ; i++) begin
        entries[i] <= TAG_W'(ARCH_REGS + i);
      end
      head_idx <= '0;
      tail_idx <= '0;
      count    <= CNT_W'(FL_SZ);
      fl_error <= 1'b0;
    end else begin
      if (push) begin
        entries[tail_idx] <= fl_bus.rob_mt_packet.retire_t_old.phys_reg;
        tail_idx          <= tail_idx + 1'b1;
      end
      if (pop) begin
        head_idx <= head_idx + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (overflow) begin
        fl_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_free_list.sv
// Scoreboard bench for free_list: the driver queues the expected offer for each
// cycle, a negedge monitor pops and compares it against the DUT outputs.
module tb_free_list;
  import free_list_pkg::*;

  logic clock;
  logic reset;
  logic fl_error;

  free_list_if bus ();

  free_list #(
    .PHYS_REGS (64),
    .ARCH_REGS (32),
    .FL_SZ     (32)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .fl_bus   (bus.slave),
    .fl_error (fl_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic       valid;
    logic [5:0] phys;
    logic [5:0] cnt;
    logic       err;
  } exp_t;

  exp_t  exp_q  [$];
  string name_q [$];

  int compared;
  int mismatched;

  int  ref_q [$];
  logic ref_err;

  // reference state of the bench
  task automatic model_reset();
    ref_q.delete();
    for (int i = 32; i < 64; i++) ref_q.push_back(i);
    ref_err = 1'b0;
  endtask

  task automatic expect_const(input string nm, input logic v, input int phys,
                              input int cnt, input logic err);
    exp_t e;
    e.valid = v;
    e.phys  = 6'(phys);
    e.cnt   = 6'(cnt);
    e.err   = err;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic expect_model(input string nm);
    expect_const(nm, ref_q.size() != 0, (ref_q.size() != 0) ? ref_q[0] : 0,
                 ref_q.size(), ref_err);
  endtask

  task automatic drive(input logic alloc, input logic ret, input logic tv, input int tag);
    bus.id_fl_packet.alloc_en                 = alloc;
    bus.rob_mt_packet.retire_en               = ret;
    bus.rob_mt_packet.retire_t_old.valid      = tv;
    bus.rob_mt_packet.retire_t_old.phys_reg   = 6'(tag);
    bus.rob_mt_packet.retire_t.valid          = 1'b1;
    bus.rob_mt_packet.retire_t.phys_reg       = 6'(tag + 1);
  endtask

  // advance one clock and apply the same inputs to the reference
  task automatic tick(input logic alloc, input logic ret, input logic tv, input int tag);
    int  sz;
    logic do_pop;
    logic do_push;
    @(posedge clock);
    #1;
    if (reset) begin
      model_reset();
    end else begin
      sz      = ref_q.size();
      do_pop  = alloc && sz != 0;
      do_push = ret && tv;
      if (do_pop) void'(ref_q.pop_front());
      if (do_push) begin
        if (sz < 32 || do_pop) ref_q.push_back(tag);
        else ref_err = 1'b1;
      end
    end
    drive(1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic step(input string nm, input logic alloc, input logic ret,
                      input logic tv, input int tag);
    expect_model(nm);
    drive(alloc, ret, tv, tag);
    tick(alloc, ret, tv, tag);
  endtask

  task automatic check(input string nm, input int act, input int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  // monitor: one queued expectation per negedge
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(negedge clock);
      if (exp_q.size() != 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        check({nm, ".valid"}, int'(bus.fl_id_packet.free_t.valid), int'(e.valid));
        check({nm, ".cnt"}, int'(bus.fl_id_packet.free_cnt), int'(e.cnt));
        check({nm, ".err"}, int'(fl_error), int'(e.err));
        if (e.valid) check({nm, ".tag"}, int'(bus.fl_id_packet.free_t.phys_reg), int'(e.phys));
      end
    end
  end

  initial begin
    int budget;
    compared   = 0;
    mismatched = 0;
    reset      = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 0);
    model_reset();
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    reset = 1'b0;

    expect_const("reset", 1'b1, 32, 32, 1'b0);
    tick(0, 0, 0, 0);

    for (int i = 0; i < 32; i++) begin
      expect_const("pop_all", 1'b1, 32 + i, 32 - i, 1'b0);
      drive(1, 0, 0, 0);
      tick(1, 0, 0, 0);
    end

    // empty: the retire goes in, the allocate is refused, no bypass
    expect_const("empty", 1'b0, 0, 0, 1'b0);
    drive(1, 1, 1, 5);
    tick(1, 1, 1, 5);
    expect_const("empty_push", 1'b1, 5, 1, 1'b0);
    tick(0, 0, 0, 0);

    for (int i = 0; i < 9; i++) step("fill10", 0, 1, 1, 10 + i);

    expect_const("both_at10", 1'b1, 5, 10, 1'b0);
    drive(1, 1, 1, 20);
    tick(1, 1, 1, 20);
    expect_const("after_both", 1'b1, 10, 10, 1'b0);
    drive(0, 1, 0, 33);
    tick(0, 1, 0, 33);
    expect_const("invalid_told", 1'b1, 10, 10, 1'b0);
    tick(0, 0, 0, 0);

    for (int i = 0; i < 10; i++) step("drain", 1, 0, 0, 0);

    // interleaved traffic that carries both pointers across the wrap
    for (int c = 0; c < 100; c++) begin
      logic p;
      logic a;
      p = (c < 80) && (c % 2 == 0);
      a = (c > 20) && (c % 2 == 1);
      step("wrap", a, p, p, (c * 7 + 3) % 64);
    end

    for (int i = 0; i < 32; i++) step("refill", 0, 1, 1, i);

    expect_const("full", 1'b1, 0, 32, 1'b0);
    drive(0, 1, 1, 7);
    tick(0, 1, 1, 7);
    expect_const("overflow", 1'b1, 0, 32, 1'b1);
    tick(0, 0, 0, 0);
    step("full_both", 1, 1, 1, 9);
    step("sticky", 1, 0, 0, 0);

    reset = 1'b1;
    drive(1, 1, 1, 3);
    tick(1, 1, 1, 3);
    reset = 1'b0;
    expect_const("mid_reset", 1'b1, 32, 32, 1'b0);
    tick(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step("post_reset", 1, 0, 0, 0);
    step("post_reset_end", 0, 0, 0, 0);

    budget = 0;
    while (exp_q.size() != 0 && budget < 10) begin
      @(posedge clock);
      budget++;
    end
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain_timeout: %0d pending, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
